// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops plus a bit-serial SLL behind a valid/ready handshake.
// Optional signed-overflow output is enabled by defining ALU_OVF_EN.
module alu_exec #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [2:0]         Ctrl,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic               In_valid,
    output logic               In_ready,
    output logic [WIDTH-1:0]   Result,
    output logic               Zero,
    output logic               Out_valid,
    input  logic               Out_ready
`ifdef ALU_OVF_EN
    ,
    output logic               Overflow
`endif
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_LW  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     shreg_q, shreg_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic [WIDTH-1:0]     alu_res;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     shifted;

`ifdef ALU_OVF_EN
    logic                 ovf_q, ovf_d;
    logic                 alu_ovf;
    logic                 add_ovf;
    logic                 sub_ovf;
`endif

    assign sum     = A + B;
    assign diff    = A - B;
    assign shifted = shreg_q << 1;

    // Single-cycle datapath; its operands are the request being accepted this edge.
    always_comb begin
        alu_res = '0;
        unique case (Ctrl)
            OP_ADD, OP_LW, OP_SW: alu_res = sum;
            OP_AND:               alu_res = A & B;
            OP_NOR:               alu_res = ~(A | B);
            OP_SLL:               alu_res = B << Shamt;
            OP_BEQ:               alu_res = diff;
            OP_SLT:               alu_res = ($signed(A) < $signed(B)) ? WIDTH'(1) : '0;
            default:              alu_res = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    // Signed overflow: operand signs agree (add) or differ (sub) and result sign flips.
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1]  != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        alu_ovf = 1'b0;
        unique case (Ctrl)
            OP_ADD, OP_LW, OP_SW: alu_ovf = add_ovf;
            OP_BEQ:               alu_ovf = sub_ovf;
            default:              alu_ovf = 1'b0;
        endcase
    end
`endif

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ALU_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (In_valid) begin
                    if ((Ctrl == OP_SLL) && (Shamt != '0)) begin
                        shreg_d = B;
                        cnt_d   = Shamt;
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
`ifdef ALU_OVF_EN
                        ovf_d    = alu_ovf;
`endif
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
`ifdef ALU_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (Out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ALU_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign In_ready  = (state_q == IDLE);
    assign Out_valid = (state_q == DONE);
    assign Result    = result_q;
    assign Zero      = zero_q;
`ifdef ALU_OVF_EN
    assign Overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed cases plus random traffic against an arithmetic model.
module tb_alu_exec;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 5;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic [2:0]    Ctrl;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [SW-1:0] Shamt;
    logic          In_valid;
    logic          In_ready;
    logic [W-1:0]  Result;
    logic          Zero;
    logic          Out_valid;
    logic          Out_ready;
`ifdef ALU_OVF_EN
    logic          Overflow;
`endif

    alu_exec #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Ctrl      (Ctrl),
        .A         (A),
        .B         (B),
        .Shamt     (Shamt),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Result    (Result),
        .Zero      (Zero),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready)
`ifdef ALU_OVF_EN
        ,
        .Overflow  (Overflow)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        int           done_edge;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   rdy_mode = 0;
    bit   seen = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Consumer readiness changes just after the edge so the monitor sees it stable.
    always @(posedge Clk) begin
        #1;
        case (rdy_mode)
            0:       Out_ready = 1'b1;
            1:       Out_ready = ($urandom_range(0, 3) != 0);
            default: Out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: signed sums in 64-bit, shift as multiplication by a power of two.
    function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [SW-1:0] s, input int now);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 0;
        e.ovf = 1'b0;
        case (c)
            3'd0, 3'd1, 3'd2: begin
                r = sa + sb;
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd6: begin
                r = sa - sb;
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd3: r = longint'(a & b);
            3'd4: r = longint'(~(a | b));
            3'd5: begin
                p = 64'sd1 << s;
                r = longint'({32'd0, b}) * p;
            end
            default: r = (sa < sb) ? 64'sd1 : 64'sd0;
        endcase
        e.res  = r[W-1:0];
        e.zero = (e.res == 0);
        e.done_edge = now + 1 + (((c == 3'd5) && (s != 0)) ? int'(s) : 0);
        return e;
    endfunction

    // Monitor: checks every cycle a result is presented, pops on handshake.
    always @(negedge Clk) begin
        if (Rst_n === 1'b1 && Out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: Out_valid with empty scoreboard, Result=0x%0h", Result);
            end else begin
                if (!seen) begin
                    check("latency", 64'(cyc), 64'(sbq[0].done_edge));
                    seen = 1'b1;
                end
                check("result", 64'(Result), 64'(sbq[0].res));
                check("zero", 64'(Zero), 64'(sbq[0].zero));
`ifdef ALU_OVF_EN
                check("overflow", 64'(Overflow), 64'(sbq[0].ovf));
`endif
                if (Out_ready === 1'b1) begin
                    void'(sbq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Waits for In_ready (driving ignored junk meanwhile), issues one request.
    task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SW-1:0] s);
        int n;
        n = 0;
        @(negedge Clk);
        while (In_ready !== 1'b1) begin
            In_valid = 1'($urandom_range(0, 1));
            Ctrl     = 3'($urandom);
            A        = $urandom;
            B        = $urandom;
            Shamt    = SW'($urandom);
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL issue_timeout: In_ready stuck at %b", In_ready);
                In_valid = 1'b0;
                return;
            end
            @(negedge Clk);
        end
        In_valid = 1'b1;
        Ctrl = c;
        A = a;
        B = b;
        Shamt = s;
        sbq.push_back(model(c, a, b, s, cyc));
        @(negedge Clk);
        In_valid = 1'b0;
        Ctrl     = 3'($urandom);
        A        = $urandom;
        B        = $urandom;
        Shamt    = SW'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge Clk);
            n++;
        end
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        In_valid = 1'b0;
        Ctrl = '0;
        A = '0;
        B = '0;
        Shamt = '0;
        Out_ready = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_in_ready", 64'(In_ready), 64'd1);
        check("rst_out_valid", 64'(Out_valid), 64'd0);
        check("rst_result", 64'(Result), 64'd0);
        check("rst_zero", 64'(Zero), 64'd0);
        Rst_n = 1'b1;

        issue(3'b000, 32'd5, 32'd7, '0);
        issue(3'b110, 32'h1234, 32'h1234, '0);
        issue(3'b110, 32'd3, 32'd5, '0);
        issue(3'b111, 32'hFFFF_FFFF, 32'd1, '0);
        issue(3'b100, 32'd0, 32'd0, '0);
        issue(3'b011, 32'h0000_F0F0, 32'h0000_FF00, '0);
        issue(3'b001, 32'hFFFF_FFFF, 32'd1, '0);
        issue(3'b010, 32'h1000, 32'h0024, '0);

        issue(3'b101, 32'hDEAD_BEEF, 32'd1, 5'd4);
        for (int i = 0; i < 4; i++) begin
            check("shift_in_ready_low", 64'(In_ready), 64'd0);
            @(negedge Clk);
        end
        issue(3'b101, 32'd0, 32'hCAFE_0001, 5'd0);
        issue(3'b101, 32'd0, 32'd1, 5'd31);
        issue(3'b101, 32'd0, 32'h0000_0003, 5'd31);
        drain();

`ifdef ALU_OVF_EN
        issue(3'b000, 32'h7FFF_FFFF, 32'd1, '0);
        issue(3'b110, 32'h8000_0000, 32'd1, '0);
        issue(3'b110, 32'd1, 32'd2, '0);
        drain();
`endif

        // Backpressure: result must stay presented and junk requests ignored.
        rdy_mode = 2;
        issue(3'b000, 32'd100, 32'd23, '0);
        for (int i = 0; i < 3; i++) begin
            In_valid = 1'b1;
            Ctrl = 3'b011;
            A = $urandom;
            B = $urandom;
            check("bp_out_valid", 64'(Out_valid), 64'd1);
            check("bp_in_ready", 64'(In_ready), 64'd0);
            @(negedge Clk);
        end
        In_valid = 1'b0;
        rdy_mode = 0;
        drain();

        // Reset in the middle of a long shift.
        issue(3'b101, 32'd0, 32'd1, 5'd20);
        repeat (5) @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        check("midrst_in_ready", 64'(In_ready), 64'd1);
        check("midrst_out_valid", 64'(Out_valid), 64'd0);
        check("midrst_result", 64'(Result), 64'd0);
        check("midrst_zero", 64'(Zero), 64'd0);
        sbq.delete();
        seen = 1'b0;
        Rst_n = 1'b1;

        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            logic [2:0]    c;
            logic [W-1:0]  a;
            logic [W-1:0]  b;
            c = 3'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            issue(c, a, b, SW'($urandom));
        end
        drain();
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
